// File: rtl/varredura_matriz_if.sv
// rtl/varredura_matriz_if.sv - pattern write / swap request channel of the LED matrix scanner
interface varredura_matriz_if;
  logic       escrever;
  logic [2:0] coluna_idx;
  logic [4:0] dado_coluna;
  logic       trocar;
  logic       pronto;
  logic       erro;

  modport master (
    output escrever,
    output coluna_idx,
    output dado_coluna,
    output trocar,
    input  pronto,
    input  erro
  );

  modport slave (
    input  escrever,
    input  coluna_idx,
    input  dado_coluna,
    input  trocar,
    output pronto,
    output erro
  );
endinterface

// File: rtl/varredura_matriz.sv
// rtl/varredura_matriz.sv - double-buffered 7x5 column-scan refresh controller (optional VARREDURA_BRILHO_EN)
module varredura_matriz #(
  parameter int DIV_WIDTH = 16,
  parameter int DIV_MAX   = 49999
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 habilitar,
`ifdef VARREDURA_BRILHO_EN
  input  logic [2:0]           brilho,
`endif
  varredura_matriz_if.slave    barramento,
  output logic [6:0]           acender_coluna,
  output logic                 saida_reg1,
  output logic                 saida_reg2,
  output logic                 saida_reg3,
  output logic                 saida_reg4,
  output logic                 saida_reg5
);

  localparam logic [0:0] PARADO = 1'b0;
  localparam logic [0:0] VARRE  = 1'b1;

  localparam logic [DIV_WIDTH-1:0] CNT_MAX = DIV_WIDTH'(DIV_MAX);

  logic [0:0]           estado;
  logic [DIV_WIDTH-1:0] cnt;
  logic [2:0]           col;
  logic                 pendente;
  logic                 erro_q;
  logic [6:0]           acender_q;
  logic [4:0]           linha_q;
  logic [4:0]           sombra [0:6];
  logic [4:0]           exibe  [0:6];

  logic aceita;
  logic fim_coluna;
  logic fim_quadro;
  logic copiar;
  logic aceso;

  // A request is only taken while no swap is outstanding, so the shadow bank is frozen during a pending swap.
  assign aceita     = barramento.escrever && !pendente;
  assign fim_coluna = (estado == VARRE) && (cnt == CNT_MAX);
  assign fim_quadro = fim_coluna && (col == 3'd6);
  assign copiar     = pendente && ((estado == PARADO) || fim_quadro);

`ifdef VARREDURA_BRILHO_EN
  localparam int PASSO = (DIV_MAX + 1) >> 3;
  logic [DIV_WIDTH+3:0] limite;
  assign limite = (DIV_WIDTH+4)'(PASSO) * {{DIV_WIDTH{1'b0}}, ({1'b0, brilho} + 4'd1)};
  assign aceso  = {4'd0, cnt} < limite;
`else
  assign aceso  = 1'b1;
`endif

  assign barramento.pronto = ~pendente;
  assign barramento.erro   = erro_q;

  assign acender_coluna = acender_q;
  assign saida_reg1     = linha_q[0];
  assign saida_reg2     = linha_q[1];
  assign saida_reg3     = linha_q[2];
  assign saida_reg4     = linha_q[3];
  assign saida_reg5     = linha_q[4];

  // Shadow bank writes and the one-cycle invalid-index pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) sombra[i] <= 5'd0;
      erro_q <= 1'b0;
    end else begin
      if (aceita && (barramento.coluna_idx != 3'd7))
        sombra[barramento.coluna_idx] <= barramento.dado_coluna;
      erro_q <= aceita && (barramento.coluna_idx == 3'd7);
    end
  end

  // Swap bookkeeping: copy at the frame wrap (or at once when stopped), otherwise latch a new request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) exibe[i] <= 5'd0;
      pendente <= 1'b0;
    end else if (copiar) begin
      for (int i = 0; i < 7; i++) exibe[i] <= sombra[i];
      pendente <= 1'b0;
    end else if (barramento.trocar && !pendente) begin
      pendente <= 1'b1;
    end
  end

  // Scan state, prescaler, column counter and the registered column/row drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= PARADO;
      cnt       <= '0;
      col       <= 3'd0;
      acender_q <= 7'd0;
      linha_q   <= 5'd0;
    end else begin
      estado <= habilitar ? VARRE : PARADO;
      if (estado == PARADO) begin
        cnt       <= '0;
        col       <= 3'd0;
        acender_q <= 7'd0;
        linha_q   <= 5'd0;
      end else begin
        cnt <= fim_coluna ? '0 : cnt + DIV_WIDTH'(1);
        if (fim_coluna)
          col <= (col == 3'd6) ? 3'd0 : col + 3'd1;
        acender_q <= aceso ? (7'b0000001 << col) : 7'd0;
        linha_q   <= aceso ? exibe[col] : 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_varredura_matriz.sv
// tb/tb_varredura_matriz.sv - self-checking bench for varredura_matriz with a frame-position reference model
module tb_varredura_matriz;

  localparam int DWELL = 8;
  localparam int FRAME = 7 * DWELL;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hab;
  logic [6:0] acender_coluna;
  logic       saida_reg1, saida_reg2, saida_reg3, saida_reg4, saida_reg5;
`ifdef VARREDURA_BRILHO_EN
  logic [2:0] brilho = 3'd7;
`endif

  int compared = 0;
  int mismatched = 0;

  varredura_matriz_if bus ();

  varredura_matriz #(.DIV_WIDTH(4), .DIV_MAX(7)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .habilitar      (hab),
`ifdef VARREDURA_BRILHO_EN
    .brilho         (brilho),
`endif
    .barramento     (bus),
    .acender_coluna (acender_coluna),
    .saida_reg1     (saida_reg1),
    .saida_reg2     (saida_reg2),
    .saida_reg3     (saida_reg3),
    .saida_reg4     (saida_reg4),
    .saida_reg5     (saida_reg5)
  );

  always #5 clk = ~clk;

  // Reference model: scan position counted in clocks since the scan started.
  logic [4:0] sh_m [7];
  logic [4:0] di_m [7];
  bit         pend_m;
  bit         en_m;
  int         pos;
  logic [6:0] ea;
  logic [4:0] el;
  logic       ee;

  task automatic model_reset();
    for (int k = 0; k < 7; k++) begin
      sh_m[k] = 5'd0;
      di_m[k] = 5'd0;
    end
    pend_m = 0;
    en_m   = 0;
    pos    = 0;
    ea     = 7'd0;
    el     = 5'd0;
    ee     = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    bit wrap;
    bit copy;
    int c;
    acc  = bus.escrever && !pend_m;
    ee   = acc && (bus.coluna_idx == 3'd7);
    wrap = 0;
    if (en_m) begin
      c    = (pos / DWELL) % 7;
      ea   = 7'(1 << c);
      el   = di_m[c];
      wrap = (pos % FRAME) == FRAME - 1;
      pos++;
    end else begin
      ea  = 7'd0;
      el  = 5'd0;
      pos = 0;
    end
    copy = pend_m && (!en_m || wrap);
    if (copy) begin
      for (int k = 0; k < 7; k++) di_m[k] = sh_m[k];
      pend_m = 0;
    end else if (bus.trocar && !pend_m) begin
      pend_m = 1;
    end
    if (acc && bus.coluna_idx != 3'd7) sh_m[bus.coluna_idx] = bus.dado_coluna;
    en_m = hab;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("acender_coluna", 32'(acender_coluna), 32'(ea));
    chk("saida_reg", 32'({saida_reg5, saida_reg4, saida_reg3, saida_reg2, saida_reg1}), 32'(el));
    chk("pronto", 32'(bus.pronto), 32'(!pend_m));
    chk("erro", 32'(bus.erro), 32'(ee));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic wr(input logic [2:0] idx, input logic [4:0] d);
    bus.escrever    = 1'b1;
    bus.coluna_idx  = idx;
    bus.dado_coluna = d;
    tick();
    bus.escrever    = 1'b0;
  endtask

  task automatic swap();
    bus.trocar = 1'b1;
    tick();
    bus.trocar = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    hab   = 1'b0;
    bus.escrever    = 1'b0;
    bus.coluna_idx  = 3'd0;
    bus.dado_coluna = 5'd0;
    bus.trocar      = 1'b0;
    model_reset();
    #12;
    check_all();
    tick();
    tick();

    rst_n = 1'b1;
    hab   = 1'b1;
    repeat (FRAME + 20) tick();

    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 7; i++) wr(3'(i), 5'(1 << (i % 5)));
    swap();
    repeat (2 * FRAME) tick();

    wr(3'd7, 5'($urandom));
    tick();
    swap();
    repeat (FRAME + 8) tick();

    wr(3'd3, 5'($urandom));
    swap();
    wr(3'd4, 5'($urandom));
    wr(3'd7, 5'($urandom));
    swap();
    repeat (FRAME) tick();

    bus.escrever    = 1'b1;
    bus.coluna_idx  = 3'd5;
    bus.dado_coluna = 5'($urandom);
    bus.trocar      = 1'b1;
    tick();
    bus.escrever    = 1'b0;
    bus.trocar      = 1'b0;
    repeat (FRAME + 8) tick();

    wr(3'd1, 5'($urandom));
    swap();
    repeat (10) tick();
    hab = 1'b0;
    repeat (3) tick();
    wr(3'd2, 5'($urandom));
    swap();
    tick();
    tick();
    hab = 1'b1;
    repeat (FRAME + 4) tick();

    repeat (600) begin
      if ($urandom_range(0, 99) == 0) hab = !hab;
      bus.escrever    = ($urandom_range(0, 3) == 0);
      bus.coluna_idx  = 3'($urandom_range(0, 7));
      bus.dado_coluna = 5'($urandom);
      bus.trocar      = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.escrever = 1'b0;
    bus.trocar   = 1'b0;
    hab = 1'b1;
    repeat (FRAME + 8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/varredura_matriz.md
# varredura_matriz

Column-scan refresh controller for the 5x7 LED matrix. Holds a double-buffered 7-column x 5-row pattern and sweeps one column at a time. It drives the one-hot column vector `acender_coluna[6:0]` and the five row lines `saida_reg1..saida_reg5` consumed by the switch-controlled line/column gating stage. Pattern writes go to a shadow bank and are swapped into the display bank only at a frame boundary, so the image never tears.

## Interface

Parameters:
- `DIV_WIDTH`, default 16: prescaler counter width.
- `DIV_MAX`, default 49999: terminal count of the prescaler. Column dwell is DIV_MAX+1 clocks. Must be ≥ 7 and < 2^DIV_WIDTH.

Ports:
- `clk` input, 1 bit: system clock, rising edge.
- `rst_n` input, 1 bit: **asynchronous, active-low** reset.
- `habilitar` input, 1 bit: scan enable.
- `escrever` input, 1 bit: shadow-bank write strobe, one cycle per write.
- `coluna_idx` input, 3 bits: target column, 0..6.
- `dado_coluna` input, 5 bits: row pattern. Bit i maps to row i+1.
- `trocar` input, 1 bit: request a shadow-to-display swap.
- `pronto` output, 1 bit: write/swap requests accepted while high.
- `erro` output, 1 bit: one-cycle pulse on an invalid write index.
- `acender_coluna` output, 7 bits: one-hot active column, active-high.
- `saida_reg1`..`saida_reg5` output, 1 bit each: row data for the active column.

## Operation

- **Storage**
  - Two banks, shadow and display, each 7 x 5 bits.
  - Column counter `col` runs 0..6.
  - Prescaler `cnt` runs 0..DIV_MAX.
  - Swap-pending flag `pendente`.
- **States**
  - PARADO: entered when `habilitar`=0. `cnt`=0, `col`=0, all column and row outputs 0.
  - VARRE: entered when `habilitar`=1.
  - A transition between states takes effect on the next clock edge.
- **Prescaler**
  - In VARRE, `cnt` increments every cycle.
  - At `cnt`==DIV_MAX the next cycle has `cnt`=0 and `col` = `col`+1.
  - `col` wraps 6→0. That wrap is the frame boundary.
- **Outputs** (registered)
  - `acender_coluna` = 1<<`col`.
  - `saida_reg(i+1)` = display[`col`][i].
- **Write**
  - An `escrever` pulse with `pronto`=1 and `coluna_idx`≤6 stores `dado_coluna` into shadow[`coluna_idx`].
  - `coluna_idx`=7: nothing is stored and `erro` pulses for one cycle.
  - `escrever` with `pronto`=0 is ignored, with no `erro`.
- **Swap**
  - `trocar` with `pronto`=1 sets `pendente`.
  - `pronto` = ~`pendente`.
  - In VARRE, the copy happens in the same clock edge where `col` wraps 6→0; that edge also clears `pendente`. Column 0 of the new frame shows the new bank.
  - In PARADO, the copy happens on the next clock edge.
  - `trocar` while `pendente`=1 is ignored.
- **Simultaneous `escrever` + `trocar`** (with `pronto`=1): the write lands in shadow first, and the swap includes it.
- **`habilitar` falling mid-frame**
  - The frame is abandoned and outputs go to 0 on the next cycle.
  - A pending swap completes on the next clock edge (PARADO rule).

## Timing

- **Reset values**
  - `acender_coluna`=0, all `saida_reg`=0, `erro`=0, `pronto`=1.
  - `col`=0, `cnt`=0, `pendente`=0, both banks all-zero.
  - Reset asserted mid-frame takes effect immediately (asynchronous).
- **`habilitar` rising** at edge k: `acender_coluna`=7'b0000001 is visible after edge k+1.
- **Dwell and frame**
  - Each column is held for exactly DIV_MAX+1 cycles.
  - Frame length = 7·(DIV_MAX+1) cycles.
- **Write-to-display latency**: the write cycle, up to one full frame until the next 6→0 wrap, plus one output register stage.
- **`erro` timing**: asserted the cycle after the bad write strobe, deasserted the following cycle.

## Configuration

- **`VARREDURA_BRILHO_EN` defined**
  - Adds input `brilho` (3 bits).
  - Define limite = ((DIV_MAX+1)>>3)·(`brilho`+1).
  - While `cnt` ≥ limite, `acender_coluna` and all `saida_reg` are forced to 0. The column counter and swap behaviour are unchanged.
  - `brilho`=7 gives near-full duty.
  - `brilho` is sampled every cycle.
- **Not defined**: no `brilho` port. Outputs are active for the full dwell.

## Test plan

Use DIV_MAX=7, DIV_WIDTH=4.

1. **Reset.** Assert `rst_n`=0 mid-scan → outputs all 0, `pronto`=1 immediately. Release, `habilitar`=1 → column 0 (7'b0000001) held for 8 cycles, then 7'b0000010; after 56 cycles back to 7'b0000001.
2. **Write and swap.** Write columns 0..6 = 5'b00001, 5'b00010, …, then `trocar`. Rows stay 0 until the 6→0 wrap. From the next frame, column 2 shows rows 5'b00100. `pronto`=0 from the `trocar` until the wrap cycle.
3. **Invalid index.** `escrever` with `coluna_idx`=7 → `erro`=1 for exactly one cycle, shadow unchanged (verified via a later swap).
4. **Pending blocks.** `escrever` while `pendente`=1 → ignored, no `erro`. `escrever` and `trocar` in the same cycle → the written data appears after the swap.
5. **Stop mid-frame.** `habilitar`=0 mid-frame with a swap pending → outputs 0 next cycle, swap completes next edge, re-enable starts at column 0 with the new bank.
6. **Brightness** (`VARREDURA_BRILHO_EN`). `brilho`=1 → each column lit for 2 of 8 dwell cycles. `brilho`=7 → lit all 8.
